// File: rtl/act_quant_lanes.sv
// act_quant_lanes: multi-lane bias / scale / ReLU / requantise pipeline.
// Optional feature macro ACT_SAT_CNT_EN adds a sticky output saturation counter.

module act_quant_lanes #(
  parameter int LANES  = 4,
  parameter int IN_W   = 32,
  parameter int OUT_W  = 8,
  parameter int BF_W   = 16,
  parameter int MANT_W = 16,
  parameter int EXP_W  = 16,
  parameter int CH     = 4,
  localparam int CH_AW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [1:0]             cfg_sel,
  input  logic [CH_AW-1:0]       cfg_ch,
  input  logic [31:0]            cfg_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH_AW-1:0]       in_ch,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data
`ifdef ACT_SAT_CNT_EN
  ,
  output logic [15:0]            sat_cnt
`endif
);

  localparam int TW  = IN_W + 1;
  localparam int PW  = TW + MANT_W + 1;
  localparam int RW  = ((PW > 63) ? PW : 63) + 1;

  localparam logic signed [RW-1:0] IN_MAX =
    {{(RW-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [RW-1:0] IN_MIN =
    {{(RW-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};
  localparam logic signed [RW-1:0] OUT_MAX =
    {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] OUT_MIN =
    {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic signed [EXP_W:0] SMAX = (EXP_W+1)'(62);
  localparam logic [CH_AW:0] CHN = (CH_AW+1)'(CH);

  // right-shift amount: negated exponent, clamped to 0..62
  function automatic logic [5:0] shamt(
    input logic signed [EXP_W-1:0] e
  );
    logic signed [EXP_W:0] ne;
    ne = -$signed({e[EXP_W-1], e});
    if (!e[EXP_W-1])
      shamt = 6'd0;
    else if (ne > SMAX)
      shamt = 6'd62;
    else
      shamt = ne[5:0];
  endfunction

  // arithmetic shift with round-half-up
  function automatic logic signed [RW-1:0] rshr(
    input logic signed [RW-1:0] p,
    input logic [5:0]           s
  );
    logic signed [RW-1:0] rnd;
    rnd = '0;
    if (s != 6'd0)
      rnd[s - 6'd1] = 1'b1;
    rshr = (p + rnd) >>> s;
  endfunction

  function automatic logic signed [IN_W-1:0] sat_in(
    input logic signed [RW-1:0] r
  );
    if (r > IN_MAX)
      sat_in = IN_MAX[IN_W-1:0];
    else if (r < IN_MIN)
      sat_in = IN_MIN[IN_W-1:0];
    else
      sat_in = r[IN_W-1:0];
  endfunction

  logic [BF_W-1:0]   bias_q [CH];
  logic [MANT_W-1:0] mw_mant;
  logic [MANT_W-1:0] ma_mant;
  logic [EXP_W-1:0]  mw_exp;
  logic [EXP_W-1:0]  ma_exp;

  logic v1;
  logic v2;
  logic stall;
  logic cfg_fire;
  logic in_fire;

  logic [LANES*TW-1:0]   t_all;
  logic [LANES*TW-1:0]   t_q;
  logic [LANES*IN_W-1:0] u_all;
  logic [LANES*IN_W-1:0] u_q;
  logic [LANES*OUT_W-1:0] o_all;
  logic [LANES-1:0]      sat_all;
  logic [LANES-1:0]      sat_q;

  logic [5:0] sh_w;
  logic [5:0] sh_a;

  logic              ch_ok;
  logic [BF_W-1:0]   bias_sel;

  assign stall     = out_valid && !out_ready;
  assign cfg_ready = !v1 && !v2 && !out_valid;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_ready  = !stall && !cfg_fire;
  assign in_fire   = in_valid && in_ready;

  assign sh_w = shamt(mw_exp);
  assign sh_a = shamt(ma_exp);

  assign ch_ok    = {1'b0, in_ch} < CHN;
  assign bias_sel = ch_ok ? bias_q[in_ch] : '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [IN_W-1:0]  x;
    logic signed [TW-1:0]    t_r;
    logic signed [RW-1:0]    p2;
    logic signed [RW-1:0]    r2;
    logic signed [IN_W-1:0]  u_c;
    logic signed [IN_W-1:0]  u_r;
    logic signed [RW-1:0]    p3;
    logic signed [RW-1:0]    r3;
    logic                    s_n;

    assign x = in_data[i*IN_W +: IN_W];
    assign t_all[i*TW +: TW] =
      {x[IN_W-1], x} +
      {{(TW-BF_W){bias_sel[BF_W-1]}}, bias_sel};

    assign t_r = t_q[i*TW +: TW];
    assign p2  = {{(RW-TW){t_r[TW-1]}}, t_r} *
                 {{(RW-MANT_W){1'b0}}, mw_mant};
    assign r2  = rshr(p2, sh_w);
    assign u_c = sat_in(r2);
    assign u_all[i*IN_W +: IN_W] = u_c[IN_W-1] ? '0 : u_c;

    assign u_r = u_q[i*IN_W +: IN_W];
    assign p3  = {{(RW-IN_W){u_r[IN_W-1]}}, u_r} *
                 {{(RW-MANT_W){1'b0}}, ma_mant};
    assign r3  = rshr(p3, sh_a);
    assign s_n = (r3 > OUT_MAX) || (r3 < OUT_MIN);
    assign sat_all[i] = s_n;
    assign o_all[i*OUT_W +: OUT_W] =
      !s_n        ? r3[OUT_W-1:0] :
      r3[RW-1]    ? OUT_MIN[OUT_W-1:0] :
                    OUT_MAX[OUT_W-1:0];
  end

  // config registers; writes only happen while the pipe is empty
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CH; k++)
        bias_q[k] <= '0;
      mw_mant <= MANT_W'(1);
      ma_mant <= MANT_W'(1);
      mw_exp  <= '0;
      ma_exp  <= '0;
    end else if (cfg_fire) begin
      unique case (1'b1)
        (cfg_sel == 2'd1): begin
          if ({1'b0, cfg_ch} < CHN)
            bias_q[cfg_ch] <= cfg_data[BF_W-1:0];
        end
        (cfg_sel == 2'd2): begin
          mw_mant <= cfg_data[MANT_W-1:0];
          mw_exp  <= cfg_data[16 +: EXP_W];
        end
        (cfg_sel == 2'd3): begin
          ma_mant <= cfg_data[MANT_W-1:0];
          ma_exp  <= cfg_data[16 +: EXP_W];
        end
        default: ;
      endcase
    end
  end

  // three-stage datapath; whole pipe freezes on output stall
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      t_q       <= '0;
      u_q       <= '0;
      out_data  <= '0;
      sat_q     <= '0;
    end else if (!stall) begin
      v1        <= in_fire;
      v2        <= v1;
      out_valid <= v2;
      if (in_fire)
        t_q <= t_all;
      if (v1)
        u_q <= u_all;
      if (v2) begin
        out_data <= o_all;
        sat_q    <= sat_all;
      end
    end
  end

`ifdef ACT_SAT_CNT_EN
  logic [15:0] sat_inc;
  logic [16:0] sat_sum;

  // number of saturated lanes in the current output beat
  always_comb begin
    sat_inc = '0;
    for (int k = 0; k < LANES; k++)
      sat_inc = sat_inc + 16'(sat_q[k]);
  end

  assign sat_sum = {1'b0, sat_cnt} + {1'b0, sat_inc};

  // sticky counter, advances once per delivered beat
  always_ff @(posedge clk) begin
    if (rst)
      sat_cnt <= '0;
    else if (out_valid && out_ready)
      sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`else
  logic unused_sat;
  assign unused_sat = ^sat_q;
`endif

endmodule

// File: tb/tb_act_quant_lanes.sv
// tb_act_quant_lanes: directed stimulus with a queue-based reference model.
// Inputs change #1 after posedge; DUT is observed on negedge.

module tb_act_quant_lanes;

  localparam int LANES = 4;
  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int CH    = 4;
  localparam int CH_AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [1:0] cfg_sel = '0;
  logic [CH_AW-1:0] cfg_ch = '0;
  logic [31:0] cfg_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [CH_AW-1:0] in_ch = '0;
  logic [LANES*IN_W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [LANES*OUT_W-1:0] out_data;
`ifdef ACT_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  act_quant_lanes dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel),
    .cfg_ch(cfg_ch),
    .cfg_data(cfg_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ch(in_ch),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef ACT_SAT_CNT_EN
    ,
    .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  longint m_bias [CH];
  longint m_mw, m_we, m_ma, m_ae;
  longint m_sat;

  typedef struct {
    logic [LANES*OUT_W-1:0] d;
    int nsat;
    int acc;
  } beat_t;

  beat_t q[$];
  int cyc = 0;
  int n_out = 0;
  int last_lat = 0;
  logic [LANES*OUT_W-1:0] last_out = '0;
  bit after_rst = 0;

  always @(posedge clk) cyc++;

  function automatic void model_reset();
    for (int k = 0; k < CH; k++) m_bias[k] = 0;
    m_mw = 1; m_we = 0;
    m_ma = 1; m_ae = 0;
    m_sat = 0;
  endfunction

  function automatic void model_cfg(input logic [1:0] sel,
                                    input int ch,
                                    input logic [31:0] d);
    logic signed [15:0] lo;
    logic signed [15:0] hi;
    lo = d[15:0];
    hi = d[31:16];
    case (sel)
      2'd1: if (ch < CH) m_bias[ch] = lo;
      2'd2: begin m_mw = longint'(d[15:0]); m_we = hi; end
      2'd3: begin m_ma = longint'(d[15:0]); m_ae = hi; end
      default: ;
    endcase
  endfunction

  function automatic longint rs(input longint p, input longint e);
    longint s;
    if (e >= 0) s = 0;
    else if (-e > 62) s = 62;
    else s = -e;
    if (s == 0) return p;
    return (p + (longint'(1) <<< (s - 1))) >>> s;
  endfunction

  function automatic longint clampl(input longint v, input longint lo,
                                    input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic beat_t expect_beat(
    input logic [LANES*IN_W-1:0] xin, input int ch);
    beat_t b;
    longint imax, omax;
    imax = (longint'(1) <<< (IN_W - 1)) - 1;
    omax = (longint'(1) <<< (OUT_W - 1)) - 1;
    b.d = '0;
    b.nsat = 0;
    b.acc = cyc;
    for (int i = 0; i < LANES; i++) begin
      logic signed [IN_W-1:0] xs;
      longint t, u, v;
      xs = xin[i*IN_W +: IN_W];
      t = longint'(xs) + ((ch < CH) ? m_bias[ch] : 0);
      u = clampl(rs(t * m_mw, m_we), -imax - 1, imax);
      if (u < 0) u = 0;
      v = rs(u * m_ma, m_ae);
      if (v > omax || v < -omax - 1) b.nsat++;
      v = clampl(v, -omax - 1, omax);
      b.d[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
    return b;
  endfunction

  // scoreboard: checks handshake rules and every output beat
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      model_reset();
      after_rst = 1;
    end else begin
      if (after_rst) begin
        chk("out_valid_after_rst", out_valid, 0);
        after_rst = 0;
      end
      chk("cfg_ready_empty", cfg_ready, q.size() == 0);
      chk("in_ready_rule", in_ready,
          !(out_valid && !out_ready) && !(cfg_valid && cfg_ready));
`ifdef ACT_SAT_CNT_EN
      chk("sat_cnt", sat_cnt, m_sat);
`endif
      if (out_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_unexpected: got %0h expected none",
                   out_data);
        end else begin
          chk("out_data", out_data, q[0].d);
          if (out_ready) begin
            beat_t b;
            b = q.pop_front();
            last_out = out_data;
            last_lat = cyc - b.acc;
            n_out++;
            m_sat = clampl(m_sat + b.nsat, 0, 65535);
          end
        end
      end
      if (cfg_valid && cfg_ready)
        model_cfg(cfg_sel, int'(cfg_ch), cfg_data);
      if (in_valid && in_ready)
        q.push_back(expect_beat(in_data, int'(in_ch)));
    end
  end

  function automatic logic [LANES*IN_W-1:0] px(
    input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic logic [LANES*OUT_W-1:0] po(
    input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [31:0] cw(input int mant, input int e);
    return {16'(e), 16'(mant)};
  endfunction

  function automatic logic [LANES*IN_W-1:0] gen(input int k);
    return px(k * 37 - 50, k * 1000, -k * 7, 12345 + k);
  endfunction

  task automatic cfg_write(input int sel, input int ch,
                           input logic [31:0] d, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    cfg_valid = 1;
    cfg_sel = 2'(sel);
    cfg_ch = CH_AW'(ch);
    cfg_data = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1; break; end
      waited++;
      @(posedge clk); #1;
    end
    chk("cfg_accept", ok, 1);
    @(posedge clk); #1;
    cfg_valid = 0;
  endtask

  task automatic cfg(input int sel, input int ch, input logic [31:0] d);
    int w;
    cfg_write(sel, ch, d, w);
  endtask

  task automatic send(input int ch, input logic [LANES*IN_W-1:0] d);
    bit ok;
    ok = 0;
    in_valid = 1;
    in_ch = CH_AW'(ch);
    in_data = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("send_accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic stream(input int n, input int ch, input int start,
                        input int max_cyc, output int acc);
    acc = 0;
    in_ch = CH_AW'(ch);
    for (int c = 0; c < max_cyc && acc < n; c++) begin
      in_valid = 1;
      in_data = gen(start + acc);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic wait_out(input int target, input string nm);
    for (int c = 0; c < 60; c++) begin
      if (n_out >= target) break;
      @(posedge clk); #1;
    end
    chk(nm, n_out >= target, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0, acc, w;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    cfg(1, 0, 32'd50);
    cfg(2, 0, cw(1, -3));
    cfg(3, 0, cw(4, -1));
    n0 = n_out;
    send(0, px(64, 0, 0, 0));
    wait_out(n0 + 1, "t1_wait");
    chk("t1_lane0", last_out[7:0], 28);
    chk("t1_all", last_out, po(28, 12, 12, 12));
    chk("t1_latency", last_lat, 3);

    cfg(1, 1, 32'd487);
    cfg(2, 0, cw(32, -5));
    cfg(3, 0, cw(512, -15));
    n0 = n_out;
    send(1, px(513, -294, 0, 1000));
    wait_out(n0 + 1, "t2_wait");
    chk("t2_out", last_out, po(16, 3, 8, 23));

    cfg(1, 2, 32'(-7849));
    n0 = n_out;
    send(2, px(-2151, 9999, 1183, 0));
    wait_out(n0 + 1, "t3_wait");
    chk("t3_out", last_out, po(0, 34, 0, 0));

    cfg(2, 0, cw(1, 0));
    cfg(3, 0, cw(1, 0));
    n0 = n_out;
    send(3, px(300, -300, 127, -128));
    wait_out(n0 + 1, "t4_wait");
    chk("t4_out", last_out, po(127, 0, 127, 0));
`ifdef ACT_SAT_CNT_EN
    chk("t4_sat_cnt", sat_cnt, 1);
`endif

    cfg(2, 0, cw(65535, -100));
    n0 = n_out;
    send(0, px(1000000000, -1000000000, 7, 0));
    wait_out(n0 + 1, "shift_clamp_wait");
    chk("shift_clamp_out", last_out, po(0, 0, 0, 0));

    cfg(0, 0, 32'hDEAD_BEEF);
    cfg(2, 0, cw(3, 4));
    n0 = n_out;
    send(0, px(-10, -45, -60, 1000000000));
    wait_out(n0 + 1, "pos_exp_wait");
    chk("pos_exp_out", last_out, po(120, 15, 0, 127));
`ifdef ACT_SAT_CNT_EN
    chk("pos_exp_sat_cnt", sat_cnt, 2);
`endif
    cfg(2, 0, cw(1, 0));

    out_ready = 0;
    n0 = n_out;
    stream(5, 3, 0, 8, acc);
    chk("t5_accepted", acc, 3);
    @(negedge clk);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1;
    stream(2, 3, 3, 20, acc);
    chk("t5_rest", acc, 2);
    wait_out(n0 + 5, "t5_wait");
    chk("t5_count", n_out - n0, 5);

    n0 = n_out;
    stream(2, 0, 10, 10, acc);
    cfg_write(1, 0, 32'(-10), w);
    chk("t6_cfg_waited", w > 0, 1);
    send(0, px(10, 100, 0, 0));
    wait_out(n0 + 3, "t6_wait");
    chk("t6_new_bias", last_out, po(0, 90, 0, 0));

    cfg_valid = 1;
    cfg_sel = 2'd0;
    in_valid = 1;
    in_ch = '0;
    in_data = px(20, 30, 40, 150);
    @(negedge clk);
    chk("t6_same_in_ready", in_ready, 0);
    chk("t6_same_cfg_ready", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 0;
    @(negedge clk);
    chk("t6_in_after_cfg", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    n0 = n_out;
    wait_out(n0 + 1, "t6_same_wait");
    chk("t6_same_out", last_out, po(10, 20, 30, 127));

    stream(3, 1, 20, 10, acc);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_cfg_ready", cfg_ready, 1);
    @(posedge clk); #1;
    n0 = n_out;
    send(0, px(5, -5, 200, 0));
    wait_out(n0 + 1, "rst_mid_wait");
    chk("rst_mid_cfg_restored", last_out, po(5, 0, 127, 0));
`ifdef ACT_SAT_CNT_EN
    chk("rst_mid_sat_cnt", sat_cnt, 1);
`endif

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
